phased_instruction_sequencer: RTL and testbench
===============================================

Name: phased_instruction_sequencer

Overview:
- Parametrised successor to the 8-bit phase-gated instruction decoder.
- Owns the fetch/decode/execute phase FSM, program counter and instruction register.
- Decodes the opcode into a one-hot strobe vector, gated by phase, and resolves conditional jumps from ALU flags.
- Sits between instruction memory and the datapath (ALU, I/O and accumulator load enables).

Parameters:
- DATA_W, 8, instruction width in bits.
- OPCODE_W, 4, opcode field width, taken from ir[DATA_W-1 -: OPCODE_W].
- PC_W, 8, program counter width.
- STROBE_MODE, 0: 0 = strobes active in DECODE and EXECUTE (legacy gating); 1 = strobes active in EXECUTE only.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  allows a new fetch to start.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_valid  in  1  imem_data valid this cycle.
- imem_data  in  DATA_W  fetched instruction.
- exec_wait  in  1  datapath stall; holds EXECUTE.
- flag_z  in  1  zero flag.
- flag_c  in  1  carry flag.
- phase  out  3  one-hot {execute, decode, fetch}.
- op_strobe  out  2**OPCODE_W  one-hot decoded opcode, phase-gated.
- illegal  out  1  unmapped opcode, phase-gated like op_strobe.
- operand  out  DATA_W-OPCODE_W  ir low field.
- pc  out  PC_W  program counter.

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock.
  - On reset: state=FETCH, pc=0, ir=0.
  - Outputs: imem_req=0 until run; op_strobe=0; illegal=0; phase=3'b001.
  - Reset asserted mid-instruction aborts it immediately: no pc update, strobes drop the same cycle.
- FSM states: FETCH, DECODE, EXECUTE.
- FETCH:
  - imem_req = run.
  - If run && imem_valid: ir<=imem_data, go to DECODE.
  - Otherwise stay in FETCH. imem_valid is ignored while run=0.
- DECODE: lasts exactly 1 cycle, then EXECUTE.
- EXECUTE:
  - Holds while exec_wait=1.
  - In the first cycle with exec_wait=0: update pc, go to FETCH.
  - Minimum 3 cycles per instruction (FETCH with immediate valid, DECODE, EXECUTE).
- Opcode map (OPCODE_W=4):
  - 0 load, 1 add, 2 sub, 3 and, 4 ip, 5 op.
  - 8 jump, 9 jumpz, 10 jumpnz, 11 jumpc, 12 jumpnc.
  - 6, 7, 13, 14, 15 are illegal.
  - For wider OPCODE_W, codes above 12 are illegal.
- Strobes:
  - op_strobe[ir opcode] is combinational from registered state and ir; all bits are 0 outside enabled phases.
  - Illegal opcode: op_strobe=0 and illegal=1 in the enabled phases; the instruction executes as a NOP (pc+1).
- Jump resolution: flags are sampled in the final EXECUTE cycle.
  - jump is always taken.
  - jumpz taken if flag_z; jumpnz if !flag_z; jumpc if flag_c; jumpnc if !flag_c.
  - Taken: pc <= zero-extended operand, truncated to PC_W if the operand is wider.
  - Not taken, or non-jump: pc <= pc+1 modulo 2**PC_W; 2**PC_W-1 wraps to 0.
- Flags changing during an exec_wait stall: only the value in the release cycle counts.
- run deasserted mid-instruction: the current instruction completes; the sequencer then parks in FETCH with imem_req=0.

Test Plan:
- Reset, then run=1 with imem_valid always 1 and data 0x15 (add, operand 5):
  - phase sequence 001,010,100 repeats;
  - op_strobe=16'h0002 in DECODE and EXECUTE (mode 0);
  - pc goes 0→1→2.
- STROBE_MODE=1, same stimulus: op_strobe=0 in DECODE and 16'h0002 only in EXECUTE.
- pc=3, instruction 0x9A (jumpz 10):
  - flag_z=1 → pc=10.
  - flag_z=0 → pc=4.
  - exec_wait=1 for 2 cycles with flag_z toggling 1→0 in the release cycle → pc=4 and EXECUTE lasts 3 cycles.
- pc=255 (PC_W=8), instruction 0x0F (load) → pc wraps to 0. Instruction 0xE0 → illegal=1, op_strobe=0, pc+1.
- imem_valid held low for 4 cycles in FETCH → imem_req stays 1, state stays FETCH, pc unchanged. run=0 → imem_req=0.
- Assert reset during EXECUTE of 0x80 → pc=0, phase=001, op_strobe=0 asynchronously, with no jump applied.

Source files
------------

// File: rtl/phased_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phased_instruction_sequencer
// Brief    : Fetch/decode/execute sequencer with phase-gated opcode strobes.
// Revision : 1.0 - initial release
// ============================================================================
module phased_instruction_sequencer #(
    parameter int DATA_W      = 8,
    parameter int OPCODE_W    = 4,
    parameter int PC_W        = 8,
    parameter int STROBE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_valid,
    input  logic [DATA_W-1:0]        imem_data,
    input  logic                     exec_wait,
    input  logic                     flag_z,
    input  logic                     flag_c,
    output logic [2:0]               phase,
    output logic [2**OPCODE_W-1:0]   op_strobe,
    output logic                     illegal,
    output logic [DATA_W-OPCODE_W-1:0] operand,
    output logic [PC_W-1:0]          pc
);

    localparam int c_OPND_W = DATA_W - OPCODE_W;
    localparam int c_NSTB   = 2**OPCODE_W;

    localparam logic [OPCODE_W-1:0] c_OP_OUT    = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] c_OP_JUMP   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] c_OP_JUMPZ  = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] c_OP_JUMPNZ = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] c_OP_JUMPC  = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] c_OP_JUMPNC = OPCODE_W'(12);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_ir;

    logic [OPCODE_W-1:0] w_opcode;
    logic [c_OPND_W-1:0] w_operand;
    logic                w_legal;
    logic                w_strobe_en;
    logic                w_taken;
    logic [PC_W-1:0]     w_target;
    logic [PC_W-1:0]     w_pc_next;
    logic [c_NSTB-1:0]   w_onehot;

    assign w_opcode  = r_ir[DATA_W-1 -: OPCODE_W];
    assign w_operand = r_ir[c_OPND_W-1:0];
    assign w_legal   = (w_opcode <= c_OP_OUT) ||
                       ((w_opcode >= c_OP_JUMP) && (w_opcode <= c_OP_JUMPNC));
    assign w_onehot  = {{(c_NSTB-1){1'b0}}, 1'b1} << w_opcode;

    generate
        if (STROBE_MODE == 1) begin : g_exec_only
            assign w_strobe_en = (r_state == ST_EXECUTE);
        end else begin : g_legacy
            assign w_strobe_en = (r_state == ST_DECODE) || (r_state == ST_EXECUTE);
        end
    endgenerate

    // Jump targets narrower than pc are zero-extended, wider ones truncated.
    generate
        if (c_OPND_W >= PC_W) begin : g_trunc
            assign w_target = w_operand[PC_W-1:0];
        end else begin : g_zext
            assign w_target = {{(PC_W-c_OPND_W){1'b0}}, w_operand};
        end
    endgenerate

    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            c_OP_JUMP:   w_taken = 1'b1;
            c_OP_JUMPZ:  w_taken = flag_z;
            c_OP_JUMPNZ: w_taken = !flag_z;
            c_OP_JUMPC:  w_taken = flag_c;
            c_OP_JUMPNC: w_taken = !flag_c;
            default:     w_taken = 1'b0;
        endcase
    end

    assign w_pc_next = w_taken ? w_target : (r_pc + PC_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (run && imem_valid) begin
                        r_ir    <= imem_data;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: r_state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    // Flags are only sampled in the release cycle of a stall.
                    if (!exec_wait) begin
                        r_pc    <= w_pc_next;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign imem_req  = (r_state == ST_FETCH) && run;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign operand   = w_operand;
    assign phase     = {r_state == ST_EXECUTE, r_state == ST_DECODE, r_state == ST_FETCH};
    assign op_strobe = (w_strobe_en && w_legal) ? w_onehot : '0;
    assign illegal   = w_strobe_en && !w_legal;

endmodule
`default_nettype wire

// File: tb/tb_phased_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phased_instruction_sequencer
// Brief    : Directed vector bench for both strobe gating modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phased_instruction_sequencer;

    localparam logic [2:0] FE = 3'b001;
    localparam logic [2:0] DE = 3'b010;
    localparam logic [2:0] EX = 3'b100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0, imem_valid = 1'b0, exec_wait = 1'b0;
    logic        flag_z = 1'b0, flag_c = 1'b0;
    logic [7:0]  imem_data = 8'h00;

    logic        req0, req1, ill0, ill1;
    logic [7:0]  addr0, addr1, pc0, pc1;
    logic [2:0]  ph0, ph1;
    logic [15:0] stb0, stb1;
    logic [3:0]  opd0, opd1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phased_instruction_sequencer #(.DATA_W(8), .OPCODE_W(4), .PC_W(8), .STROBE_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .run(run), .imem_req(req0), .imem_addr(addr0),
        .imem_valid(imem_valid), .imem_data(imem_data), .exec_wait(exec_wait),
        .flag_z(flag_z), .flag_c(flag_c), .phase(ph0), .op_strobe(stb0),
        .illegal(ill0), .operand(opd0), .pc(pc0)
    );

    phased_instruction_sequencer #(.DATA_W(8), .OPCODE_W(4), .PC_W(8), .STROBE_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .run(run), .imem_req(req1), .imem_addr(addr1),
        .imem_valid(imem_valid), .imem_data(imem_data), .exec_wait(exec_wait),
        .flag_z(flag_z), .flag_c(flag_c), .phase(ph1), .op_strobe(stb1),
        .illegal(ill1), .operand(opd1), .pc(pc1)
    );

    typedef struct {
        logic        run, valid;
        logic [7:0]  data;
        logic        ew, z, c;
        logic [2:0]  ph;
        logic        req;
        logic [15:0] s0, s1;
        logic        i0, i1;
        logic [7:0]  pc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic ew, input logic z, input logic c,
                       input logic [2:0] ph, input logic rq,
                       input logic [15:0] s0, input logic [15:0] s1,
                       input logic i0, input logic i1, input logic [7:0] p);
        vec_t t;
        t.run = r; t.valid = v; t.data = d; t.ew = ew; t.z = z; t.c = c;
        t.ph = ph; t.req = rq; t.s0 = s0; t.s1 = s1; t.i0 = i0; t.i1 = i1; t.pc = p;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic ew, input logic z, input logic c);
        @(negedge clk);
        run = r; imem_valid = v; imem_data = d; exec_wait = ew; flag_z = z; flag_c = c;
    endtask

    task automatic instr(input logic [7:0] d);
        step(1, 1, d, 0, 0, 0);
        step(1, 1, d, 0, 0, 0);
        step(1, 1, d, 0, 0, 0);
    endtask

    initial begin
        // Three-cycle add instructions, then jumps with and without stalls.
        add(1,1,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd0);
        add(1,1,8'h15,0,0,0, DE,0, 16'h0002,16'h0000,0,0, 8'd0);
        add(1,1,8'h15,0,0,0, EX,0, 16'h0002,16'h0002,0,0, 8'd0);
        add(1,1,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd1);
        add(1,1,8'h15,0,0,0, DE,0, 16'h0002,16'h0000,0,0, 8'd1);
        add(1,1,8'h15,0,0,0, EX,0, 16'h0002,16'h0002,0,0, 8'd1);
        add(1,1,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd2);
        add(1,1,8'h15,0,0,0, DE,0, 16'h0002,16'h0000,0,0, 8'd2);
        add(1,1,8'h15,0,0,0, EX,0, 16'h0002,16'h0002,0,0, 8'd2);
        add(1,1,8'h9A,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd3);
        add(1,1,8'h9A,0,0,0, DE,0, 16'h0200,16'h0000,0,0, 8'd3);
        add(1,1,8'h9A,0,1,0, EX,0, 16'h0200,16'h0200,0,0, 8'd3);
        add(1,1,8'h83,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd10);
        add(1,1,8'h83,0,0,0, DE,0, 16'h0100,16'h0000,0,0, 8'd10);
        add(1,1,8'h83,0,0,0, EX,0, 16'h0100,16'h0100,0,0, 8'd10);
        add(1,1,8'h9A,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd3);
        add(1,1,8'h9A,0,0,0, DE,0, 16'h0200,16'h0000,0,0, 8'd3);
        add(1,1,8'h9A,0,0,0, EX,0, 16'h0200,16'h0200,0,0, 8'd3);
        add(1,1,8'h83,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd4);
        add(1,1,8'h83,0,0,0, DE,0, 16'h0100,16'h0000,0,0, 8'd4);
        add(1,1,8'h83,0,0,0, EX,0, 16'h0100,16'h0100,0,0, 8'd4);
        add(1,1,8'h9A,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd3);
        add(1,1,8'h9A,0,0,0, DE,0, 16'h0200,16'h0000,0,0, 8'd3);
        add(1,1,8'h9A,1,1,0, EX,0, 16'h0200,16'h0200,0,0, 8'd3);
        add(1,1,8'h9A,1,1,0, EX,0, 16'h0200,16'h0200,0,0, 8'd3);
        add(1,1,8'h9A,0,0,0, EX,0, 16'h0200,16'h0200,0,0, 8'd3);
        add(1,1,8'hB7,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd4);
        add(1,1,8'hB7,0,0,0, DE,0, 16'h0800,16'h0000,0,0, 8'd4);
        add(1,1,8'hB7,0,0,1, EX,0, 16'h0800,16'h0800,0,0, 8'd4);
        add(1,1,8'hC0,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd7);
        add(1,1,8'hC0,0,0,0, DE,0, 16'h1000,16'h0000,0,0, 8'd7);
        add(1,1,8'hC0,0,0,1, EX,0, 16'h1000,16'h1000,0,0, 8'd7);
        add(1,1,8'hA5,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd8);
        add(1,1,8'hA5,0,0,0, DE,0, 16'h0400,16'h0000,0,0, 8'd8);
        add(1,1,8'hA5,0,0,0, EX,0, 16'h0400,16'h0400,0,0, 8'd8);
        // Illegal opcode executes as a NOP.
        add(1,1,8'hE0,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd5);
        add(1,1,8'hE0,0,0,0, DE,0, 16'h0000,16'h0000,1,0, 8'd5);
        add(1,1,8'hE0,0,0,0, EX,0, 16'h0000,16'h0000,1,1, 8'd5);
        // Fetch waits on imem_valid, ignores it while run=0.
        add(1,0,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd6);
        add(1,0,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd6);
        add(1,0,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd6);
        add(1,0,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd6);
        add(0,1,8'h15,0,0,0, FE,0, 16'h0000,16'h0000,0,0, 8'd6);
        add(0,1,8'h15,0,0,0, FE,0, 16'h0000,16'h0000,0,0, 8'd6);
        add(1,1,8'h15,0,0,0, FE,1, 16'h0000,16'h0000,0,0, 8'd6);
        add(0,1,8'h15,0,0,0, DE,0, 16'h0002,16'h0000,0,0, 8'd6);
        add(0,1,8'h15,0,0,0, EX,0, 16'h0002,16'h0002,0,0, 8'd6);
        add(0,1,8'h15,0,0,0, FE,0, 16'h0000,16'h0000,0,0, 8'd7);
        add(0,1,8'h15,0,0,0, FE,0, 16'h0000,16'h0000,0,0, 8'd7);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_phase0", 32'(ph0), 32'(FE));
        chk("rst_phase1", 32'(ph1), 32'(FE));
        chk("rst_pc0", 32'(pc0), 32'd0);
        chk("rst_req0", 32'(req0), 32'd0);
        chk("rst_stb0", 32'(stb0), 32'd0);
        chk("rst_ill0", 32'(ill0), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].run, vq[i].valid, vq[i].data, vq[i].ew, vq[i].z, vq[i].c);
            #1;
            chk($sformatf("v%0d_phase", i), 32'(ph0), 32'(vq[i].ph));
            chk($sformatf("v%0d_phase_m1", i), 32'(ph1), 32'(vq[i].ph));
            chk($sformatf("v%0d_req", i), 32'(req0), 32'(vq[i].req));
            chk($sformatf("v%0d_stb_m0", i), 32'(stb0), 32'(vq[i].s0));
            chk($sformatf("v%0d_stb_m1", i), 32'(stb1), 32'(vq[i].s1));
            chk($sformatf("v%0d_ill_m0", i), 32'(ill0), 32'(vq[i].i0));
            chk($sformatf("v%0d_ill_m1", i), 32'(ill1), 32'(vq[i].i1));
            chk($sformatf("v%0d_pc", i), 32'(pc0), 32'(vq[i].pc));
            chk($sformatf("v%0d_pc_m1", i), 32'(pc1), 32'(vq[i].pc));
            chk($sformatf("v%0d_addr", i), 32'(addr0), 32'(vq[i].pc));
        end

        // Step loads up to pc=255, then one more must wrap to 0.
        for (int k = 0; k < 300; k++) begin
            if (pc0 == 8'd255) break;
            instr(8'h0F);
            @(negedge clk);
            run = 1'b0;
        end
        #1;
        chk("wrap_pre_pc", 32'(pc0), 32'd255);
        instr(8'h0F);
        step(0, 0, 8'h00, 0, 0, 0);
        #1;
        chk("wrap_pc0", 32'(pc0), 32'd0);
        chk("wrap_pc1", 32'(pc1), 32'd0);
        chk("wrap_phase", 32'(ph0), 32'(FE));

        // Asynchronous reset while a jump sits stalled in EXECUTE.
        instr(8'h05);
        step(1, 1, 8'h80, 0, 0, 0);
        step(1, 1, 8'h80, 0, 0, 0);
        step(1, 1, 8'h80, 1, 0, 0);
        #1;
        chk("arst_pre_phase", 32'(ph0), 32'(EX));
        chk("arst_pre_stb", 32'(stb0), 32'h0100);
        chk("arst_pre_pc", 32'(pc0), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_pc0", 32'(pc0), 32'd0);
        chk("arst_pc1", 32'(pc1), 32'd0);
        chk("arst_phase", 32'(ph0), 32'(FE));
        chk("arst_stb0", 32'(stb0), 32'd0);
        chk("arst_stb1", 32'(stb1), 32'd0);
        step(1, 0, 8'h00, 0, 0, 0);
        reset = 1'b0;
        step(1, 0, 8'h00, 0, 0, 0);
        #1;
        chk("post_rst_phase", 32'(ph0), 32'(FE));
        chk("post_rst_pc", 32'(pc0), 32'd0);
        chk("post_rst_req", 32'(req0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
